// File: rtl/airport_security_multilane.sv
// Multi-lane airport security controller.
// One passenger is accepted at a time through a valid/ready gate. Baggage
// parity and the passenger's type decide whether a timed inspection hold comes
// first. The passenger is then assigned to a screening lane by class and lane
// occupancy, and each assignment issues an LFSR-derived security token.
//
// Handshake: a passenger is accepted on a rising edge where arrive_valid and
// arrive_ready are both high. arrive_ready is high only in IDLE. The gate holds
// type and data stable until acceptance. assign_valid is a one-cycle pulse, and
// assign_lane, assign_priority and security_token are valid while it is high.
// The lane and class are kept until the next assignment, and so is the token.
module airport_security_multilane #(
  parameter int          LANES       = 4,
  parameter int          MAX_OCC     = 8,
  parameter int          DATA_W      = 8,
  parameter int          INSPECT_CYC = 4,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  localparam int         CNT_W       = $clog2(MAX_OCC + 1),
  localparam int         LW          = $clog2(LANES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arrive_valid,
  input  logic [1:0]               arrive_type,
  input  logic [DATA_W-1:0]        baggage_data,
  output logic                     arrive_ready,
  input  logic [LANES-1:0]         lane_exit,
  output logic                     assign_valid,
  output logic [LW-1:0]            assign_lane,
  output logic [1:0]               assign_priority,
  output logic [7:0]               security_token,
  output logic [LANES*CNT_W-1:0]   lane_count,
  output logic [2*LANES-1:0]       lane_light,
  output logic                     parity_alarm,
  output logic                     full_stall
);

  localparam int TW = (INSPECT_CYC > 1) ? $clog2(INSPECT_CYC) : 1;
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_OCC);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(MAX_OCC / 2);
  localparam logic [LW-1:0]    INSP_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_INSPECT = 2'd2,
    S_ASSIGN  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [1:0]         type_q;
  logic [DATA_W-1:0]  data_q;
  logic               insp_q;
  logic [7:0]         lfsr_q;
  logic [CNT_W-1:0]   cnt_q [LANES];
  logic [CNT_W-1:0]   cnt_d [LANES];

  logic               av_q;
  logic [LW-1:0]      lane_q;
  logic [1:0]         prio_q;
  logic [7:0]         token_q;

  logic               accept;
  logic               set_insp;
  logic               do_assign;
  logic               err;
  logic [7:0]         data8;
  logic [LW-1:0]      gen_lane;
  logic [CNT_W-1:0]   gen_min;
  logic [LW-1:0]      tgt;
  logic               tgt_full;

  // The token always mixes in an 8-bit view of the captured baggage word.
  if (DATA_W >= 8) begin : g_data_wide
    assign data8 = data_q[7:0];
  end else begin : g_data_narrow
    assign data8 = {{(8 - DATA_W){1'b0}}, data_q};
  end

  assign err = (^data_q) | (type_q == 2'b11);

  // Pick the least-occupied general lane; ties keep the lowest index.
  always_comb begin
    gen_lane = LW'(1);
    gen_min  = cnt_q[1];
    for (int i = 2; i <= LANES - 2; i++) begin
      if (cnt_q[i] < gen_min) begin
        gen_min  = cnt_q[i];
        gen_lane = LW'(i);
      end
    end
  end

  // Pick the target lane from the passenger class and the current occupancy.
  always_comb begin
    tgt = gen_lane;
    if (insp_q) begin
      tgt = INSP_LANE;
    end else if ((type_q == 2'b10) && (cnt_q[0] != MAX_C)) begin
      tgt = '0;
    end
    tgt_full = (cnt_q[tgt] == MAX_C);
  end

  // Compute the next state, the inspection timer and the gate/assign strobes.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    accept    = 1'b0;
    set_insp  = 1'b0;
    do_assign = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arrive_valid) begin
          accept  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (err) begin
          set_insp = 1'b1;
          timer_d  = TW'(INSPECT_CYC - 1);
          state_d  = S_INSPECT;
        end else begin
          state_d = S_ASSIGN;
        end
      end
      S_INSPECT: begin
        if (timer_q == '0) begin
          state_d = S_ASSIGN;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_ASSIGN: begin
        if (!tgt_full) begin
          do_assign = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign arrive_ready = (state_q == S_IDLE);
  assign parity_alarm = (state_q == S_INSPECT);
  assign full_stall   = (state_q == S_ASSIGN) && tgt_full;

  // Register the FSM state, the inspection timer and the captured passenger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      type_q  <= '0;
      data_q  <= '0;
      insp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (accept) begin
        type_q <= arrive_type;
        data_q <= baggage_data;
        insp_q <= 1'b0;
      end else if (set_insp) begin
        insp_q <= 1'b1;
      end
    end
  end

  // Advance the token LFSR every cycle, stalls included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // Register the assignment pulse and hold its lane, class and token.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      av_q    <= 1'b0;
      lane_q  <= '0;
      prio_q  <= '0;
      token_q <= '0;
    end else begin
      av_q <= do_assign;
      if (do_assign) begin
        lane_q  <= tgt;
        prio_q  <= insp_q ? 2'b11 : type_q;
        token_q <= lfsr_q ^ data8;
      end
    end
  end

  assign assign_valid    = av_q;
  assign assign_lane     = lane_q;
  assign assign_priority = prio_q;
  assign security_token  = token_q;

  // Occupancy update: an assignment adds one, an exit removes one unless the lane is empty.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      logic inc;
      logic dec;
      inc = do_assign && (tgt == LW'(i));
      dec = lane_exit[i] && (cnt_q[i] != '0);
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!inc && dec) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // Register the per-lane occupancy counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Flatten the counts and derive the status lights; the inspection light wins.
  always_comb begin
    lane_count = '0;
    lane_light = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_count[i*CNT_W +: CNT_W] = cnt_q[i];
      if ((i == LANES - 1) && (state_q == S_INSPECT)) begin
        lane_light[2*i +: 2] = 2'b11;
      end else if (cnt_q[i] == MAX_C) begin
        lane_light[2*i +: 2] = 2'b10;
      end else if (cnt_q[i] >= HALF_C) begin
        lane_light[2*i +: 2] = 2'b01;
      end else begin
        lane_light[2*i +: 2] = 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_airport_security_multilane.sv
// Bench for airport_security_multilane: scenario tasks checked against a
// behavioural lane/occupancy/token model kept in the bench.
module tb_airport_security_multilane;

  localparam int         LANES       = 4;
  localparam int         MAX_OCC     = 8;
  localparam int         DATA_W      = 8;
  localparam int         INSPECT_CYC = 4;
  localparam logic [7:0] SEED        = 8'hA5;
  localparam int         CNT_W       = 4;

  logic                   clk;
  logic                   reset;
  logic                   arrive_valid;
  logic [1:0]             arrive_type;
  logic [DATA_W-1:0]      baggage_data;
  logic                   arrive_ready;
  logic [LANES-1:0]       lane_exit;
  logic                   assign_valid;
  logic [1:0]             assign_lane;
  logic [1:0]             assign_priority;
  logic [7:0]             security_token;
  logic [LANES*CNT_W-1:0] lane_count;
  logic [2*LANES-1:0]     lane_light;
  logic                   parity_alarm;
  logic                   full_stall;

  int vectors = 0;
  int miscompares = 0;

  int         m_cnt [LANES];
  logic [7:0] m_lfsr;
  logic [7:0] m_prev;

  airport_security_multilane #(
    .LANES(LANES), .MAX_OCC(MAX_OCC), .DATA_W(DATA_W),
    .INSPECT_CYC(INSPECT_CYC), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset),
    .arrive_valid(arrive_valid), .arrive_type(arrive_type),
    .baggage_data(baggage_data), .arrive_ready(arrive_ready),
    .lane_exit(lane_exit), .assign_valid(assign_valid),
    .assign_lane(assign_lane), .assign_priority(assign_priority),
    .security_token(security_token), .lane_count(lane_count),
    .lane_light(lane_light), .parity_alarm(parity_alarm),
    .full_stall(full_stall)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    // Fibonacci LFSR, taps at positions 8,6,5,4 (1-based), shifting left.
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // m_prev holds the LFSR value the design saw just before the latest edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  function automatic bit is_inspected(input logic [1:0] t, input logic [7:0] d);
    return (^d) || (t == 2'b11);
  endfunction

  function automatic int model_target(input logic [1:0] t, input logic [7:0] d);
    int best;
    if (is_inspected(t, d)) return LANES - 1;
    if (t == 2'b10 && m_cnt[0] < MAX_OCC) return 0;
    best = 1;
    for (int i = 2; i <= LANES - 2; i++) begin
      if (m_cnt[i] < m_cnt[best]) best = i;
    end
    return best;
  endfunction

  function automatic logic [1:0] model_light(input int i, input bit inspecting);
    if (i == LANES - 1 && inspecting) return 2'b11;
    if (m_cnt[i] == MAX_OCC) return 2'b10;
    if (m_cnt[i] >= MAX_OCC / 2) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int dut_cnt(input int i);
    return int'(lane_count[i*CNT_W +: CNT_W]);
  endfunction

  task automatic model_commit(input int tgt, input logic [LANES-1:0] ex);
    for (int i = 0; i < LANES; i++) begin
      int pre;
      pre = m_cnt[i];
      if (ex[i] && pre > 0) m_cnt[i] = m_cnt[i] - 1;
      if (i == tgt) m_cnt[i] = m_cnt[i] + 1;
    end
  endtask

  // ---------------- driver tasks (all start and end at a negedge) ----------------
  task automatic do_reset();
    reset = 1'b1;
    arrive_valid = 1'b0;
    arrive_type = '0;
    baggage_data = '0;
    lane_exit = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < LANES; i++) m_cnt[i] = 0;
  endtask

  task automatic accept_passenger(input logic [1:0] t, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    arrive_valid = 1'b1;
    arrive_type = t;
    baggage_data = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (arrive_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    arrive_valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL accept_timeout: got no acceptance, required acceptance within 50 cycles");
    end
  endtask

  task automatic wait_assign(input logic [LANES-1:0] ex_mask, output int n,
                             output int alarm_n, output int light_bad);
    bit got;
    got = 1'b0;
    n = 0;
    alarm_n = 0;
    light_bad = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      n++;
      if (n == 2) lane_exit = '0;
      if (parity_alarm === 1'b1) begin
        alarm_n++;
        if (lane_light[2*LANES-1 -: 2] !== 2'b11) light_bad++;
      end
      if (assign_valid === 1'b1) got = 1'b1;
      else if (n == 1) lane_exit = ex_mask;
    end
    lane_exit = '0;
    vectors++;
    if (!got) begin
      miscompares++;
      n = -1;
      $display("FAIL assign_timeout: got no assign_valid, required one within 50 cycles");
    end
  endtask

  task automatic pulse_exit(input logic [LANES-1:0] mask);
    lane_exit = mask;
    @(negedge clk);
    lane_exit = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i] && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    vectors++;
    if (arrive_ready !== 1'b1) begin miscompares++;
      $display("FAIL rst_ready: got %0b required 1", arrive_ready); end
    vectors++;
    if ({assign_valid, assign_lane, assign_priority, parity_alarm, full_stall} !== 7'd0) begin
      miscompares++;
      $display("FAIL rst_ctrl: got %b required 0", {assign_valid, assign_lane, assign_priority, parity_alarm, full_stall});
    end
    vectors++;
    if (security_token !== 8'h00) begin miscompares++;
      $display("FAIL rst_token: got %h required 00", security_token); end
    vectors++;
    if (lane_count !== '0) begin miscompares++;
      $display("FAIL rst_count: got %h required 0", lane_count); end
    vectors++;
    if (lane_light !== '0) begin miscompares++;
      $display("FAIL rst_light: got %b required 0", lane_light); end
  endtask

  task automatic test_regular();
    int n, a, lb, tgt;
    logic [7:0] exp_tok, held;
    do_reset();
    tgt = model_target(2'b00, 8'h03);
    accept_passenger(2'b00, 8'h03);
    wait_assign('0, n, a, lb);
    exp_tok = m_prev ^ 8'h03;
    model_commit(tgt, '0);
    vectors++;
    if (n !== 2) begin miscompares++; $display("FAIL reg_latency: got %0d required 2", n); end
    vectors++;
    if (assign_lane !== 2'd1) begin miscompares++; $display("FAIL reg_lane: got %0d required 1", assign_lane); end
    vectors++;
    if (assign_priority !== 2'b00) begin miscompares++; $display("FAIL reg_prio: got %b required 00", assign_priority); end
    vectors++;
    if (security_token !== exp_tok) begin miscompares++; $display("FAIL reg_token: got %h required %h", security_token, exp_tok); end
    vectors++;
    if (dut_cnt(1) !== 1) begin miscompares++; $display("FAIL reg_count1: got %0d required 1", dut_cnt(1)); end
    held = security_token;
    @(negedge clk);
    vectors++;
    if (assign_valid !== 1'b0) begin miscompares++; $display("FAIL reg_pulse: got %0b required 0", assign_valid); end
    vectors++;
    if (security_token !== exp_tok) begin miscompares++; $display("FAIL reg_token_hold: got %h required %h", security_token, exp_tok); end
  endtask

  task automatic test_vip_fill();
    int n, a, lb, tgt;
    logic [7:0] exp_tok;
    do_reset();
    for (int v = 0; v < 9; v++) begin
      tgt = model_target(2'b10, 8'hAA);
      accept_passenger(2'b10, 8'hAA);
      wait_assign('0, n, a, lb);
      exp_tok = m_prev ^ 8'hAA;
      model_commit(tgt, '0);
      vectors++;
      if (assign_lane !== 2'(tgt) || tgt !== ((v < 8) ? 0 : 1)) begin miscompares++;
        $display("FAIL vip_lane[%0d]: got %0d required %0d", v, assign_lane, (v < 8) ? 0 : 1); end
      vectors++;
      if (assign_priority !== 2'b10) begin miscompares++;
        $display("FAIL vip_prio[%0d]: got %b required 10", v, assign_priority); end
      vectors++;
      if (security_token !== exp_tok) begin miscompares++;
        $display("FAIL vip_token[%0d]: got %h required %h", v, security_token, exp_tok); end
      vectors++;
      if (lane_light[1:0] !== model_light(0, 1'b0)) begin miscompares++;
        $display("FAIL vip_light0[%0d]: got %b required %b", v, lane_light[1:0], model_light(0, 1'b0)); end
    end
    vectors++;
    if (dut_cnt(0) !== 8 || dut_cnt(1) !== 1) begin miscompares++;
      $display("FAIL vip_counts: got %0d/%0d required 8/1", dut_cnt(0), dut_cnt(1)); end
  endtask

  task automatic test_inspect();
    logic [1:0] types [2] = '{2'b00, 2'b11};
    logic [7:0] datas [2] = '{8'h01, 8'h00};
    int n, a, lb, tgt;
    logic [7:0] exp_tok;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      tgt = model_target(types[k], datas[k]);
      accept_passenger(types[k], datas[k]);
      wait_assign('0, n, a, lb);
      exp_tok = m_prev ^ datas[k];
      model_commit(tgt, '0);
      vectors++;
      if (a !== INSPECT_CYC) begin miscompares++; $display("FAIL insp_alarm_cycles[%0d]: got %0d required %0d", k, a, INSPECT_CYC); end
      vectors++;
      if (lb !== 0) begin miscompares++; $display("FAIL insp_light3[%0d]: got %0d bad cycles required 0", k, lb); end
      vectors++;
      if (n !== 2 + INSPECT_CYC) begin miscompares++; $display("FAIL insp_latency[%0d]: got %0d required %0d", k, n, 2 + INSPECT_CYC); end
      vectors++;
      if (assign_lane !== 2'd3) begin miscompares++; $display("FAIL insp_lane[%0d]: got %0d required 3", k, assign_lane); end
      vectors++;
      if (assign_priority !== 2'b11) begin miscompares++; $display("FAIL insp_prio[%0d]: got %b required 11", k, assign_priority); end
      vectors++;
      if (security_token !== exp_tok) begin miscompares++; $display("FAIL insp_token[%0d]: got %h required %h", k, security_token, exp_tok); end
      vectors++;
      if (parity_alarm !== 1'b0 || lane_light[7:6] !== model_light(3, 1'b0)) begin miscompares++;
        $display("FAIL insp_after[%0d]: got alarm %0b light %b required 0 / %b", k, parity_alarm, lane_light[7:6], model_light(3, 1'b0)); end
    end
  endtask

  task automatic test_full_stall();
    int n, a, lb, tgt;
    logic [7:0] d, exp_tok;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom_range(0, 255));
      if (^d) d = d ^ 8'h01;
      tgt = model_target(2'b00, d);
      accept_passenger(2'b00, d);
      wait_assign('0, n, a, lb);
      model_commit(tgt, '0);
      vectors++;
      if (assign_lane !== 2'(tgt)) begin miscompares++; $display("FAIL fill_lane[%0d]: got %0d required %0d", k, assign_lane, tgt); end
    end
    d = 8'h5A;
    accept_passenger(2'b00, d);
    repeat (2) @(negedge clk);
    vectors++;
    if (full_stall !== 1'b1 || arrive_ready !== 1'b0 || assign_valid !== 1'b0) begin miscompares++;
      $display("FAIL stall_flags: got stall %0b ready %0b valid %0b required 1 0 0", full_stall, arrive_ready, assign_valid); end
    vectors++;
    if (lane_light[5:2] !== 4'b1010) begin miscompares++; $display("FAIL stall_lights: got %b required 1010", lane_light[5:2]); end
    pulse_exit(4'b0100);
    vectors++;
    if (dut_cnt(2) !== 7 || full_stall !== 1'b0) begin miscompares++;
      $display("FAIL stall_exit: got count %0d stall %0b required 7 0", dut_cnt(2), full_stall); end
    tgt = model_target(2'b00, d);
    wait_assign('0, n, a, lb);
    exp_tok = m_prev ^ d;
    model_commit(tgt, '0);
    vectors++;
    if (n !== 1 || assign_lane !== 2'd2) begin miscompares++;
      $display("FAIL stall_release: got latency %0d lane %0d required 1 2", n, assign_lane); end
    vectors++;
    if (security_token !== exp_tok) begin miscompares++; $display("FAIL stall_token: got %h required %h", security_token, exp_tok); end
    vectors++;
    if (dut_cnt(2) !== 8) begin miscompares++; $display("FAIL stall_count2: got %0d required 8", dut_cnt(2)); end
  endtask

  task automatic test_same_cycle_exit();
    int n, a, lb, tgt;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      tgt = model_target(2'b00, 8'h00);
      accept_passenger(2'b00, 8'h00);
      wait_assign('0, n, a, lb);
      model_commit(tgt, '0);
    end
    tgt = model_target(2'b00, 8'h11);
    accept_passenger(2'b00, 8'h11);
    wait_assign(4'b0010, n, a, lb);
    model_commit(tgt, 4'b0010);
    vectors++;
    if (assign_lane !== 2'd1) begin miscompares++; $display("FAIL same_lane: got %0d required 1", assign_lane); end
    vectors++;
    if (dut_cnt(1) !== m_cnt[1] || m_cnt[1] !== 1) begin miscompares++;
      $display("FAIL same_count1: got %0d required 1", dut_cnt(1)); end
    pulse_exit(4'b1000);
    vectors++;
    if (dut_cnt(3) !== 0) begin miscompares++; $display("FAIL exit_empty: got %0d required 0", dut_cnt(3)); end
  endtask

  task automatic test_reset_in_inspect();
    int n, a, lb, tgt, seen;
    logic [7:0] exp_tok;
    do_reset();
    tgt = model_target(2'b01, 8'h00);
    accept_passenger(2'b01, 8'h00);
    wait_assign('0, n, a, lb);
    model_commit(tgt, '0);
    accept_passenger(2'b11, 8'h00);
    repeat (3) @(negedge clk);
    vectors++;
    if (parity_alarm !== 1'b1) begin miscompares++; $display("FAIL rin_alarm: got %0b required 1", parity_alarm); end
    reset = 1'b1;
    #1;
    for (int i = 0; i < LANES; i++) m_cnt[i] = 0;
    vectors++;
    if ({assign_valid, assign_lane, assign_priority, parity_alarm, full_stall} !== 7'd0 || security_token !== 8'h00) begin
      miscompares++;
      $display("FAIL rin_outputs: got %b tok %h required 0", {assign_valid, assign_lane, assign_priority, parity_alarm, full_stall}, security_token);
    end
    vectors++;
    if (lane_count !== '0 || lane_light !== '0) begin miscompares++;
      $display("FAIL rin_counts: got %h lights %b required 0", lane_count, lane_light); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (assign_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL rin_no_assign: got %0d pulses required 0", seen); end
    tgt = model_target(2'b00, 8'h0F);
    accept_passenger(2'b00, 8'h0F);
    wait_assign('0, n, a, lb);
    exp_tok = m_prev ^ 8'h0F;
    model_commit(tgt, '0);
    vectors++;
    if (n !== 2 || assign_lane !== 2'd1 || security_token !== exp_tok) begin miscompares++;
      $display("FAIL rin_fresh: got lat %0d lane %0d tok %h required 2 1 %h", n, assign_lane, security_token, exp_tok); end
  endtask

  task automatic test_random();
    int n, a, lb, tgt, guard;
    logic [1:0] t;
    logic [7:0] d, exp_tok;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      pulse_exit(LANES'($urandom_range(0, 15)));
      t = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      tgt = model_target(t, d);
      guard = 0;
      while (m_cnt[tgt] >= MAX_OCC && guard < 8) begin
        pulse_exit(LANES'(1 << tgt));
        tgt = model_target(t, d);
        guard++;
      end
      accept_passenger(t, d);
      wait_assign('0, n, a, lb);
      exp_tok = m_prev ^ d;
      model_commit(tgt, '0);
      vectors++;
      if (assign_lane !== 2'(tgt) || assign_priority !== (is_inspected(t, d) ? 2'b11 : t)) begin miscompares++;
        $display("FAIL rnd_route[%0d]: got lane %0d prio %b required %0d %b", k, assign_lane, assign_priority, tgt, is_inspected(t, d) ? 2'b11 : t); end
      vectors++;
      if (security_token !== exp_tok) begin miscompares++;
        $display("FAIL rnd_token[%0d]: got %h required %h", k, security_token, exp_tok); end
      vectors++;
      if (n !== (is_inspected(t, d) ? 2 + INSPECT_CYC : 2)) begin miscompares++;
        $display("FAIL rnd_latency[%0d]: got %0d required %0d", k, n, is_inspected(t, d) ? 2 + INSPECT_CYC : 2); end
      for (int i = 0; i < LANES; i++) begin
        vectors++;
        if (dut_cnt(i) !== m_cnt[i]) begin miscompares++;
          $display("FAIL rnd_count[%0d][%0d]: got %0d required %0d", k, i, dut_cnt(i), m_cnt[i]); end
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    reset = 1'b1;
    arrive_valid = 1'b0;
    arrive_type = '0;
    baggage_data = '0;
    lane_exit = '0;
    test_reset();
    test_regular();
    test_vip_fill();
    test_inspect();
    test_full_stall();
    test_same_cycle_exit();
    test_reset_in_inspect();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
